fir_coeff_ctrl: RTL and testbench

- Run-time coefficient controller for the 17-tap transposed-form low-pass FIR in the CSI extractor input path.
- Owns two coefficient banks: a shadow bank written over a config channel, and an active bank driven to the FIR.
- Swaps banks between accepted samples, then flags the transient outputs so the downstream stage drops them.
- Sits inline on the FIR input handshake and gates valid/ready for exactly one cycle per swap.

---
 rtl/fir_coeff_pkg.sv | 23 ++
 rtl/fir_coeff_bank.sv | 37 +++
 rtl/fir_coeff_ctrl.sv | 92 +++++++++
 tb/tb_fir_coeff_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_coeff_pkg.sv
// Shared constants, types and reset coefficients for the FIR coefficient controller.
package fir_coeff_pkg;

  localparam int unsigned NUM_TAPS    = 17;
  localparam int unsigned COEFF_WIDTH = 8;
  localparam int unsigned ADDR_WIDTH  = $clog2(NUM_TAPS);
  // Settle counter must reach NUM_TAPS-1.
  localparam int unsigned CNT_WIDTH   = (NUM_TAPS > 2) ? $clog2(NUM_TAPS) : 1;

  typedef logic signed [COEFF_WIDTH-1:0] coeff_t;

  localparam coeff_t DEFAULT_COEFFS [NUM_TAPS] = '{
    -8'sd1, -8'sd2, -8'sd2, 8'sd0, 8'sd6, 8'sd13, 8'sd21, 8'sd27, 8'sd29,
    8'sd27, 8'sd21, 8'sd13, 8'sd6, 8'sd0, -8'sd2, -8'sd2, -8'sd1
  };

  typedef enum logic [1:0] {
    StIdle,
    StSwap,
    StSettle
  } state_e;

endpackage

// File: rtl/fir_coeff_bank.sv
// Shadow/active coefficient register banks; commit copies the whole shadow into active.
module fir_coeff_bank
  import fir_coeff_pkg::*;
(
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            we_i,
  input  logic [ADDR_WIDTH-1:0]           waddr_i,
  input  coeff_t                          wdata_i,
  input  logic                            commit_i,
  output logic [NUM_TAPS*COEFF_WIDTH-1:0] coeffs_o
);

  coeff_t shadow_q [NUM_TAPS];
  coeff_t active_q [NUM_TAPS];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shadow_q <= DEFAULT_COEFFS;
      active_q <= DEFAULT_COEFFS;
    end else begin
      for (int unsigned i = 0; i < NUM_TAPS; i++) begin
        if (we_i && (waddr_i == ADDR_WIDTH'(i))) begin
          shadow_q[i] <= wdata_i;
        end
        if (commit_i) begin
          active_q[i] <= shadow_q[i];
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_TAPS; g++) begin : g_flat
    assign coeffs_o[g*COEFF_WIDTH +: COEFF_WIDTH] = active_q[g];
  end

endmodule

// File: rtl/fir_coeff_ctrl.sv
// Run-time coefficient controller: config channel, bank swap FSM and FIR input gating.
module fir_coeff_ctrl
  import fir_coeff_pkg::*;
(
  input  logic                            s00_axis_aclk,
  input  logic                            s00_axis_areset,
  input  logic                            cfg_valid,
  output logic                            cfg_ready,
  input  logic                            cfg_commit,
  input  logic [ADDR_WIDTH-1:0]           cfg_addr,
  input  logic [COEFF_WIDTH-1:0]          cfg_data,
  output logic                            cfg_err,
  input  logic                            up_tvalid,
  output logic                            up_tready,
  output logic                            fir_tvalid,
  input  logic                            fir_tready,
  output logic [NUM_TAPS*COEFF_WIDTH-1:0] coeffs,
  output logic                            settling,
  output logic                            busy
);

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 cfg_err_q;

  logic hold, accept, cfg_fire, wr_fire, addr_ok;

  // Hold the stream for the swap cycle so no sample straddles the bank change.
  assign hold       = (state_q == StSwap);
  assign fir_tvalid = up_tvalid & ~hold;
  assign up_tready  = fir_tready & ~hold;
  assign accept     = fir_tvalid & fir_tready;

  assign cfg_ready = (state_q == StIdle) & ~s00_axis_areset;
  assign cfg_fire  = cfg_valid & cfg_ready;
  assign wr_fire   = cfg_fire & ~cfg_commit;
  assign addr_ok   = (cfg_addr < ADDR_WIDTH'(NUM_TAPS));

  assign cfg_err  = cfg_err_q;
  assign settling = (state_q == StSettle) & ~s00_axis_areset;
  assign busy     = (state_q != StIdle) & ~s00_axis_areset;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (cfg_fire && cfg_commit) begin
          state_d = StSwap;
        end
      end
      StSwap: begin
        cnt_d   = '0;
        state_d = (NUM_TAPS == 1) ? StIdle : StSettle;
      end
      StSettle: begin
        if (accept) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_WIDTH'(NUM_TAPS - 2)) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge s00_axis_aclk) begin
    if (s00_axis_areset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (wr_fire && !addr_ok) begin
        cfg_err_q <= 1'b1;
      end
    end
  end

  fir_coeff_bank u_bank (
    .clk_i    (s00_axis_aclk),
    .rst_i    (s00_axis_areset),
    .we_i     (wr_fire & addr_ok),
    .waddr_i  (cfg_addr),
    .wdata_i  (coeff_t'(cfg_data)),
    .commit_i (hold),
    .coeffs_o (coeffs)
  );

endmodule

// File: tb/tb_fir_coeff_ctrl.sv
// Bench for fir_coeff_ctrl: directed scenarios plus random traffic against a behavioural model.
module tb_fir_coeff_ctrl;

  localparam int NT = 17;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_valid, cfg_ready, cfg_commit, cfg_err;
  logic [4:0]    cfg_addr;
  logic [7:0]    cfg_data;
  logic          up_tvalid, up_tready, fir_tvalid, fir_tready;
  logic [NT*CW-1:0] coeffs;
  logic          settling, busy;

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  // Behavioural model: banks as int arrays, swap pending flag, samples left to flag.
  int DEF [NT] = '{-1, -2, -2, 0, 6, 13, 21, 27, 29, 27, 21, 13, 6, 0, -2, -2, -1};
  int m_shadow [NT];
  int m_active [NT];
  bit m_swap;
  int m_left;
  bit m_err;

  always #5 clk = ~clk;

  fir_coeff_ctrl dut (
    .s00_axis_aclk   (clk),
    .s00_axis_areset (rst),
    .cfg_valid       (cfg_valid),
    .cfg_ready       (cfg_ready),
    .cfg_commit      (cfg_commit),
    .cfg_addr        (cfg_addr),
    .cfg_data        (cfg_data),
    .cfg_err         (cfg_err),
    .up_tvalid       (up_tvalid),
    .up_tready       (up_tready),
    .fir_tvalid      (fir_tvalid),
    .fir_tready      (fir_tready),
    .coeffs          (coeffs),
    .settling        (settling),
    .busy            (busy)
  );

  task automatic chk(input string name, input logic [NT*CW-1:0] act, input logic [NT*CW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic int tap(input int i);
    return int'($signed(coeffs[i*CW +: CW]));
  endfunction

  task automatic model_step();
    bit acc, idle;
    if (rst) begin
      m_shadow = DEF;
      m_active = DEF;
      m_swap   = 0;
      m_left   = 0;
      m_err    = 0;
    end else begin
      acc  = up_tvalid && fir_tready && !m_swap;
      idle = !m_swap && (m_left == 0);
      if (idle) begin
        if (cfg_valid) begin
          if (cfg_commit) m_swap = 1;
          else if (int'(cfg_addr) < NT) m_shadow[cfg_addr] = int'($signed(cfg_data));
          else m_err = 1;
        end
      end else if (m_swap) begin
        m_active = m_shadow;
        m_swap   = 0;
        m_left   = NT - 1;
      end else if (acc) begin
        m_left--;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [NT*CW-1:0] exp_c;
      bit idle;
      idle = !m_swap && (m_left == 0);
      for (int i = 0; i < NT; i++) exp_c[i*CW +: CW] = 8'(m_active[i]);
      chk("fir_tvalid", fir_tvalid, up_tvalid & !m_swap);
      chk("up_tready", up_tready, fir_tready & !m_swap);
      chk("cfg_ready", cfg_ready, idle & !rst);
      chk("settling", settling, (m_left > 0) & !rst);
      chk("busy", busy, !idle & !rst);
      chk("cfg_err", cfg_err, m_err);
      chk("coeffs", coeffs, exp_c);
    end
  end

  // Present a cfg beat until it is accepted; reports cycles spent with cfg_ready low.
  task automatic cfg_beat(input bit commit, input int addr, input int data, output int stalls);
    bit took;
    stalls     = 0;
    cfg_valid  = 1;
    cfg_commit = commit;
    cfg_addr   = 5'(addr);
    cfg_data   = 8'(data);
    #1;
    for (int k = 0; k < 200; k++) begin
      took = cfg_ready;
      if (!took) stalls++;
      tick();
      if (took) break;
    end
    if (!took) chk_int("cfg_beat_timeout", 0, 1);
    cfg_valid  = 0;
    cfg_commit = 0;
    #1;
  endtask

  task automatic run_settle(output int holds, output int flagged);
    bit done = 0;
    holds   = 0;
    flagged = 0;
    for (int k = 0; k < 300; k++) begin
      if (!busy) begin
        done = 1;
        break;
      end
      if (up_tvalid && !fir_tvalid) holds++;
      if (settling && fir_tvalid && fir_tready) flagged++;
      tick();
    end
    if (!done) chk_int("settle_timeout", 0, 1);
  endtask

  int st, holds, flagged;

  initial begin
    rst = 1; cfg_valid = 0; cfg_commit = 0; cfg_addr = '0; cfg_data = '0;
    up_tvalid = 0; fir_tready = 0;
    tick();
    chk_en = 1;
    tick();
    rst = 0;
    up_tvalid = 1;
    fir_tready = 1;
    repeat (3) tick();
    chk_int("rst_tap8", tap(8), 29);
    chk_int("rst_tap0", tap(0), -1);
    chk_int("idle_cfg_ready", cfg_ready, 1);
    chk_int("idle_busy", busy, 0);

    // Write tap 8 and commit under continuous traffic.
    cfg_beat(0, 8, 40, st);
    chk_int("pre_commit_tap8", tap(8), 29);
    cfg_beat(1, 0, 0, st);
    chk_int("swap_cycle_tap8", tap(8), 29);
    run_settle(holds, flagged);
    chk_int("hold_cycles", holds, 1);
    chk_int("settle_samples", flagged, 16);
    chk_int("new_tap8", tap(8), 40);

    // Out-of-range write is sticky and harmless.
    cfg_beat(0, 20, 5, st);
    #1;
    chk_int("err_set", cfg_err, 1);
    cfg_beat(1, 0, 0, st);
    run_settle(holds, flagged);
    chk_int("err_sticky", cfg_err, 1);
    chk_int("err_tap8", tap(8), 40);

    // Stall mid-settle: counter must hold.
    cfg_beat(1, 0, 0, st);
    tick();
    repeat (5) tick();
    fir_tready = 0;
    repeat (10) tick();
    chk_int("stall_settling", settling, 1);
    fir_tready = 1;
    #1;
    run_settle(holds, flagged);
    chk_int("stall_resume_samples", flagged, 11);

    // Cfg write while busy waits for idle and lands only in the shadow.
    cfg_beat(1, 0, 0, st);
    tick();
    cfg_beat(0, 3, 77, st);
    chk_int("busy_cfg_stalls", st, 16);
    chk_int("shadow_only_tap3", tap(3), 0);
    cfg_beat(1, 0, 0, st);
    run_settle(holds, flagged);
    chk_int("committed_tap3", tap(3), 77);

    // Reset on the 4th settle sample.
    cfg_beat(1, 0, 0, st);
    tick();
    repeat (3) tick();
    rst = 1;
    tick();
    rst = 0;
    #1;
    chk_int("rst_mid_busy", busy, 0);
    chk_int("rst_mid_settling", settling, 0);
    chk_int("rst_mid_err", cfg_err, 0);
    chk_int("rst_mid_tap8", tap(8), 29);
    chk_int("rst_mid_tap3", tap(3), 0);

    // Random traffic against the model.
    for (int k = 0; k < 4000; k++) begin
      rst        = ($urandom_range(0, 299) == 0);
      cfg_valid  = ($urandom_range(0, 3) == 0);
      cfg_commit = ($urandom_range(0, 5) == 0);
      cfg_addr   = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(17, 31))
                                               : 5'($urandom_range(0, 16));
      cfg_data   = 8'($urandom);
      up_tvalid  = ($urandom_range(0, 3) != 0);
      fir_tready = ($urandom_range(0, 3) != 0);
      tick();
    end

    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
